// File: rtl/patgen_pkg.sv
// Shared types and helpers for the video test-pattern source.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package patgen_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pat_mode_t;

    // Position along a line in bar coordinates: scrolled x, offset within
    // the current bar and the bar index. Tracked incrementally, no divider.
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] cnt;
        logic [2:0]  idx;
    } bar_pos_t;

    // Counter width for a counter running 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bar colour table as {r,g,b} on/off flags; the top expands each flag
    // to a full-scale component.
    function automatic logic [2:0] bar_flags(input logic [2:0] idx);
        logic [2:0] f;
        case (idx)
            3'd0:    f = 3'b111; // white
            3'd1:    f = 3'b110; // yellow
            3'd2:    f = 3'b011; // cyan
            3'd3:    f = 3'b010; // green
            3'd4:    f = 3'b101; // magenta
            3'd5:    f = 3'b100; // red
            3'd6:    f = 3'b001; // blue
            default: f = 3'b000; // black
        endcase
        return f;
    endfunction

    // Advance one pixel. x wraps at h_active back to bar 0; once the last
    // bar is reached the index sticks there, so remainder pixels keep the
    // last bar's colour.
    function automatic bar_pos_t bar_step(input bar_pos_t p, input int h_active,
                                          input int bw, input int num_bars);
        bar_pos_t n;
        n = p;
        if (int'(p.x) == h_active - 1) begin
            n = '0;
        end else begin
            n.x = p.x + 16'd1;
            if (int'(p.cnt) == bw - 1) begin
                n.cnt = '0;
                if (int'(p.idx) < num_bars - 1)
                    n.idx = p.idx + 3'd1;
            end else begin
                n.cnt = p.cnt + 16'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/patgen_timing.sv
// Raster timing: h/v counters, sync windows, display enable, start-of-frame.
// Latency: combinational decode of the stage-0 counter registers.
// Backpressure: none; free-running at one pixel per clock.
module patgen_timing
    import patgen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HW       = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [HW-1:0] hcount_o,
    output logic [VW-1:0] vcount_o,
    output logic          de_o,
    output logic          h_act_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          sof_o
);
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [HW-1:0] h_q;
    logic [VW-1:0] v_q;

    // Raster counters: h wraps every line, v steps on the h wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == HW'(HT - 1)) begin
            h_q <= '0;
            v_q <= (v_q == VW'(VT - 1)) ? '0 : v_q + VW'(1);
        end else begin
            h_q <= h_q + HW'(1);
        end
    end

    // Decode the current position; hs/vs are raw window flags, polarity
    // is applied downstream.
    always_comb begin
        hcount_o = h_q;
        vcount_o = v_q;
        h_act_o  = 32'(h_q) < H_ACTIVE;
        de_o     = h_act_o && (32'(v_q) < V_ACTIVE);
        hs_o     = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
        vs_o     = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
        sof_o    = (h_q == '0) && (v_q == '0);
    end

endmodule

// File: rtl/pattern_gen.sv
// Video test-pattern source (bars/gradient/checker/solid) with own raster timing.
// Latency: 2 cycles counters->outputs; sync, de, counts and RGB stay aligned.
// Backpressure: none. Optional PATGEN_SCROLL_EN scrolls bars/checker 1 px/frame.
module pattern_gen
    import patgen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_SZ   = 8,
    parameter int NUM_BARS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            mode_i,
    input  logic [3*PIX_SZ-1:0]   color_i,
    output logic [cnt_width(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] hcount_o,
    output logic [cnt_width(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] vcount_o,
    output logic                  de_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic [PIX_SZ-1:0]     r_o,
    output logic [PIX_SZ-1:0]     g_o,
    output logic [PIX_SZ-1:0]     b_o,
    output logic                  frame_o
);
    localparam int HW         = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW         = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int BW         = H_ACTIVE / NUM_BARS;
    localparam int FULL       = 1 << PIX_SZ;
    localparam int GRAD_STEPS = FULL / H_ACTIVE + 1;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          de, h_act, hs_raw, vs_raw, sof;

    patgen_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk_i(clk_i), .rst_i(rst_i),
        .hcount_o(h), .vcount_o(v),
        .de_o(de), .h_act_o(h_act), .hs_o(hs_raw), .vs_o(vs_raw), .sof_o(sof)
    );

    // The mode used for pixel (0,0) is the live input, so a whole frame
    // renders with one mode and a mid-frame change waits for the next frame.
    pat_mode_t mode_q, mode_cur;
    assign mode_cur = sof ? pat_mode_t'(mode_i) : mode_q;

    // Frame-synchronous mode latch.
    always_ff @(posedge clk_i) begin
        if (rst_i)    mode_q <= PAT_BARS;
        else if (sof) mode_q <= mode_cur;
    end

    // Line start position in bar coordinates (the per-frame scroll offset).
    bar_pos_t off_cur;
`ifdef PATGEN_SCROLL_EN
    bar_pos_t off_q;
    assign off_cur = sof ? bar_step(off_q, H_ACTIVE, BW, NUM_BARS) : off_q;

    // Offset steps by one pixel at every frame start, wrapping at H_ACTIVE.
    always_ff @(posedge clk_i) begin
        if (rst_i)    off_q <= '0;
        else if (sof) off_q <= off_cur;
    end
`else
    assign off_cur = '0;
`endif

    bar_pos_t pos_q, pos_cur, pos_nxt;
    logic [31:0] acc_q, acc_cur, acc_nxt;
    logic [PIX_SZ-1:0] lvl_q, lvl_cur, lvl_nxt;

    // Per-line walkers: preload at h=0, advance once per active pixel.
    always_comb begin
        pos_cur = (h == '0) ? off_cur : pos_q;
        acc_cur = (h == '0) ? '0 : acc_q;
        lvl_cur = (h == '0) ? '0 : lvl_q;
        pos_nxt = pos_cur;
        acc_nxt = acc_cur;
        lvl_nxt = lvl_cur;
        if (h_act) begin
            pos_nxt = bar_step(pos_cur, H_ACTIVE, BW, NUM_BARS);
            acc_nxt = acc_cur + 32'(FULL);
            for (int i = 0; i < GRAD_STEPS; i++) begin
                if (acc_nxt >= 32'(H_ACTIVE)) begin
                    acc_nxt = acc_nxt - 32'(H_ACTIVE);
                    if (lvl_nxt != '1) lvl_nxt = lvl_nxt + PIX_SZ'(1);
                end
            end
        end
    end

    // Walker state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_q <= '0;
            acc_q <= '0;
            lvl_q <= '0;
        end else begin
            pos_q <= pos_nxt;
            acc_q <= acc_nxt;
            lvl_q <= lvl_nxt;
        end
    end

    logic [PIX_SZ-1:0] pr, pg, pb;
    logic [2:0]        bf;

    // Pattern select; blanking is forced to black in every mode.
    always_comb begin
        pr = '0;
        pg = '0;
        pb = '0;
        bf = bar_flags(pos_cur.idx);
        if (de) begin
            case (mode_cur)
                PAT_BARS: begin
                    pr = {PIX_SZ{bf[2]}};
                    pg = {PIX_SZ{bf[1]}};
                    pb = {PIX_SZ{bf[0]}};
                end
                PAT_GRAD: begin
                    pr = lvl_cur;
                    pg = lvl_cur;
                    pb = lvl_cur;
                end
                PAT_CHECK: begin
                    if (pos_cur.x[4] ^ (((32'(v) >> 4) & 32'd1) != 32'd0)) begin
                        pr = '1;
                        pg = '1;
                        pb = '1;
                    end
                end
                default: {pr, pg, pb} = color_i;
            endcase
        end
    end

    logic [HW-1:0]     s1_h;
    logic [VW-1:0]     s1_v;
    logic              s1_de, s1_hs, s1_vs, s1_fr;
    logic [PIX_SZ-1:0] s1_r, s1_g, s1_b;

    // Stage 1: capture pattern result with its timing; syncs take polarity here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_h  <= '0;
            s1_v  <= '0;
            s1_de <= 1'b0;
            s1_hs <= ~HS_POL;
            s1_vs <= ~VS_POL;
            s1_fr <= 1'b0;
            s1_r  <= '0;
            s1_g  <= '0;
            s1_b  <= '0;
        end else begin
            s1_h  <= h;
            s1_v  <= v;
            s1_de <= de;
            s1_hs <= hs_raw ? HS_POL : ~HS_POL;
            s1_vs <= vs_raw ? VS_POL : ~VS_POL;
            s1_fr <= sof;
            s1_r  <= pr;
            s1_g  <= pg;
            s1_b  <= pb;
        end
    end

    // Stage 2: output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcount_o <= '0;
            vcount_o <= '0;
            de_o     <= 1'b0;
            hsync_o  <= ~HS_POL;
            vsync_o  <= ~VS_POL;
            frame_o  <= 1'b0;
            r_o      <= '0;
            g_o      <= '0;
            b_o      <= '0;
        end else begin
            hcount_o <= s1_h;
            vcount_o <= s1_v;
            de_o     <= s1_de;
            hsync_o  <= s1_hs;
            vsync_o  <= s1_vs;
            frame_o  <= s1_fr;
            r_o      <= s1_r;
            g_o      <= s1_g;
            b_o      <= s1_b;
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Randomised scoreboard bench for pattern_gen on a small raster.
module tb_pattern_gen;
    localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
    localparam int VA = 40, VFP = 2, VSY = 3, VBP = 3;
    localparam int PS = 8, NB = 3;
    localparam bit HSP = 1'b0, VSP = 1'b1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [1:0]    mode_i = 2'd0;
    logic [23:0]   color_i = 24'h0;
    logic [HW-1:0] hcount_o;
    logic [VW-1:0] vcount_o;
    logic          de_o, hsync_o, vsync_o, frame_o;
    logic [PS-1:0] r_o, g_o, b_o;

    pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .PIX_SZ(PS), .NUM_BARS(NB)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .color_i(color_i),
        .hcount_o(hcount_o), .vcount_o(vcount_o),
        .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .r_o(r_o), .g_o(g_o), .b_o(b_o), .frame_o(frame_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h; int v;
        bit de; bit hs; bit vs; bit fr;
        int r; int g; int b;
    } px_t;

    px_t sb_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    // Reference model state (raster position, latched mode, frame count).
    int mh = 0, mv = 0, mmode = 0, nframes = 0;
    bit rst_s = 1'b1;

    function automatic bit [2:0] bar_colour(input int i);
        bit [2:0] t [8];
        t = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
        return t[i];
    endfunction

    // Expected output for pixel (h,v), straight from the raster/pattern rules.
    function automatic px_t model(input int h, input int v, input int mode,
                                  input logic [23:0] col, input int off);
        px_t e;
        int x, idx, lvl;
        bit [2:0] f;
        e.h  = h;
        e.v  = v;
        e.de = (h < HA) && (v < VA);
        e.hs = (h >= HA + HFP && h < HA + HFP + HSY) ? HSP : !HSP;
        e.vs = (v >= VA + VFP && v < VA + VFP + VSY) ? VSP : !VSP;
        e.fr = (h == 0) && (v == 0);
        e.r = 0; e.g = 0; e.b = 0;
        if (e.de) begin
            x = (h + off) % HA;
            case (mode)
                0: begin
                    idx = x / (HA / NB);
                    if (idx > NB - 1) idx = NB - 1;
                    f = bar_colour(idx);
                    e.r = f[2] ? 255 : 0;
                    e.g = f[1] ? 255 : 0;
                    e.b = f[0] ? 255 : 0;
                end
                1: begin
                    lvl = (h * 256) / HA;
                    if (lvl > 255) lvl = 255;
                    e.r = lvl; e.g = lvl; e.b = lvl;
                end
                2: begin
                    if ((((x >> 4) ^ (v >> 4)) & 1) == 1) begin
                        e.r = 255; e.g = 255; e.b = 255;
                    end
                end
                default: begin
                    e.r = int'(col[23:16]);
                    e.g = int'(col[15:8]);
                    e.b = int'(col[7:0]);
                end
            endcase
        end
        return e;
    endfunction

    // One clock of stimulus; when out of reset, push the expectation for
    // the pixel the counters hold during this cycle.
    task automatic step(input bit rst);
        int off;
        @(posedge clk);
        #1;
        rst_i = rst;
        if (rst) begin
            sb_q.delete();
            mh = 0; mv = 0; nframes = 0;
        end else begin
            if ($urandom_range(63) == 0) color_i = 24'($urandom());
            if ($urandom_range(1999) == 0) mode_i = 2'($urandom_range(3));
            if (mv == 10 && mh == 0) mode_i = 2'(nframes % 4);
            if (mh == 0 && mv == 0) begin
                mmode = int'(mode_i);
                nframes++;
            end
`ifdef PATGEN_SCROLL_EN
            off = nframes % HA;
`else
            off = 0;
`endif
            sb_q.push_back(model(mh, mv, mmode, color_i, off));
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
    endtask

    // Track whether the last clock edge saw reset.
    initial forever begin
        @(posedge clk);
        rst_s = rst_i;
    end

    // Monitor: reset-state checks, scoreboard pops and frame-period checks.
    initial begin
        px_t e;
        int ncyc, last_fr;
        ncyc = 0;
        last_fr = -1;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst_s) begin
                last_fr = -1;
                n_vec++;
                if (de_o !== 1'b0 || hsync_o !== !HSP || vsync_o !== !VSP || frame_o !== 1'b0 ||
                    hcount_o !== '0 || vcount_o !== '0 || r_o !== '0 || g_o !== '0 || b_o !== '0) begin
                    n_bad++;
                    $display("FAIL reset_state: got de/hs/vs/fr=%b%b%b%b cnt=%0d,%0d rgb=%02x%02x%02x, want 0%b%b0 cnt=0,0 rgb=000000",
                             de_o, hsync_o, vsync_o, frame_o, hcount_o, vcount_o, r_o, g_o, b_o, !HSP, !VSP);
                end
            end else if (sb_q.size() > 2) begin
                e = sb_q.pop_front();
                n_vec++;
                if (int'(hcount_o) != e.h || int'(vcount_o) != e.v || de_o !== e.de ||
                    hsync_o !== e.hs || vsync_o !== e.vs || frame_o !== e.fr ||
                    int'(r_o) != e.r || int'(g_o) != e.g || int'(b_o) != e.b) begin
                    n_bad++;
                    $display("FAIL pixel: got cnt=%0d,%0d de/hs/vs/fr=%b%b%b%b rgb=%0d/%0d/%0d, want cnt=%0d,%0d de/hs/vs/fr=%b%b%b%b rgb=%0d/%0d/%0d",
                             hcount_o, vcount_o, de_o, hsync_o, vsync_o, frame_o, r_o, g_o, b_o,
                             e.h, e.v, e.de, e.hs, e.vs, e.fr, e.r, e.g, e.b);
                end
                if (frame_o === 1'b1) begin
                    if (last_fr >= 0) begin
                        n_vec++;
                        if (ncyc - last_fr != HT * VT) begin
                            n_bad++;
                            $display("FAIL frame_period: got %0d cycles, want %0d", ncyc - last_fr, HT * VT);
                        end
                    end
                    last_fr = ncyc;
                end
            end
        end
    end

    initial begin
        repeat (5) step(1'b1);
        repeat (HT * VT * 2 + 1234) step(1'b0);
        repeat (3) step(1'b1);
        repeat (HT * VT * 4 + 10) step(1'b0);
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
